// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler owning the select of a shared 4:1 one-bit mux.
// A hold counter rotates the grant after MAX_HOLD cycles when others are waiting.
module mux4_rr_sched #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] I,
    output logic [3:0] gnt,
    output logic [1:0] S,
    output logic       busy,
    output logic       Y
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    owner_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    gnt_q;
    logic [1:0]    s_q;
    logic          busy_q;

    logic [3:0]    others;
    logic [1:0]    ptr_d;
    logic [1:0]    idle_win_d;
    logic [1:0]    rot_win_d;
    logic [CW-1:0] cnt_inc_d;

    // First set bit of r scanning p, p+1, p+2, p+3 (mod 4).
    function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        logic       found;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Excluding the owner guarantees a rotation never re-grants it.
    assign others     = req & ~(4'b0001 << owner_q);
    assign ptr_d      = owner_q + 2'd1;
    assign idle_win_d = arb(req, ptr_q);
    assign rot_win_d  = arb(others, ptr_d);
    assign cnt_inc_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            s_q     <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= GRANT;
                        owner_q <= idle_win_d;
                        gnt_q   <= 4'b0001 << idle_win_d;
                        s_q     <= idle_win_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        gnt_q  <= 4'b0000;
                        busy_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[owner_q] || (cnt_q == CNT_MAX && |others)) begin
                        // Release and timeout both advance the pointer past the owner.
                        ptr_q <= ptr_d;
                        if (|others) begin
                            owner_q <= rot_win_d;
                            gnt_q   <= 4'b0001 << rot_win_d;
                            s_q     <= rot_win_d;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 4'b0000;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign S    = s_q;
    assign busy = busy_q;
    assign Y    = busy_q ? I[s_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: one instance at MAX_HOLD=8, one at MAX_HOLD=1.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req8, I8, req1, I1;
    logic [3:0] gnt8, gnt1;
    logic [1:0] S8, S1;
    logic       busy8, busy1, Y8, Y1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_sched #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .I(I8),
        .gnt(gnt8), .S(S8), .busy(busy8), .Y(Y8)
    );

    mux4_rr_sched #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .I(I1),
        .gnt(gnt1), .S(S1), .busy(busy1), .Y(Y1)
    );

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req8  = 4'b0000;
        req1  = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req8  = 4'b1111;
        I8    = 4'b1111;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt8, busy8} !== 5'b0000_0) begin
            errors++;
            $display("FAIL reset_req_ignored gnt=%b busy=%b expected 0000/0", gnt8, busy8);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt8, S8, busy8} !== 7'b0001_00_1) begin
            errors++;
            $display("FAIL reset_first_grant gnt=%b S=%b busy=%b expected 0001/00/1", gnt8, S8, busy8);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt8, S8, busy8, Y8} !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL reset_async gnt=%b S=%b busy=%b Y=%b expected 0000/00/0/0", gnt8, S8, busy8, Y8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req8  = 4'b1001;
        @(negedge clk);
        checks++;
        if ({gnt8, S8, busy8} !== 7'b0001_00_1) begin
            errors++;
            $display("FAIL reset_after_release gnt=%b S=%b busy=%b expected 0001/00/1", gnt8, S8, busy8);
        end
    endtask

    // Owner 0 drops with nothing else pending -> idle, ptr=1; then 0100 wins from ptr 1.
    task automatic test_single;
        req8 = 4'b0000;
        @(negedge clk);
        checks++;
        if ({gnt8, busy8} !== 5'b0000_0) begin
            errors++;
            $display("FAIL single_idle gnt=%b busy=%b expected 0000/0", gnt8, busy8);
        end
        req8 = 4'b0100;
        I8   = 4'b0100;
        @(negedge clk);
        checks++;
        if ({gnt8, S8, busy8, Y8} !== 8'b0100_10_1_1) begin
            errors++;
            $display("FAIL single_grant gnt=%b S=%b busy=%b Y=%b expected 0100/10/1/1", gnt8, S8, busy8, Y8);
        end
        I8 = 4'b0000;
        #1;
        checks++;
        if (Y8 !== 1'b0) begin
            errors++;
            $display("FAIL single_y_comb Y=%b expected 0", Y8);
        end
        req8 = 4'b0000;
        @(negedge clk);
        checks++;
        if ({gnt8, S8, busy8, Y8} !== 8'b0000_10_0_0) begin
            errors++;
            $display("FAIL single_release gnt=%b S=%b busy=%b Y=%b expected 0000/10/0/0", gnt8, S8, busy8, Y8);
        end
    endtask

    task automatic test_contention;
        logic [1:0] eo;
        logic [3:0] eg;
        apply_reset();
        req8 = 4'b1111;
        I8   = 4'b0101;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                eo = 2'(g % 4);
                eg = 4'b0001 << eo;
                checks++;
                if ({gnt8, S8, busy8, Y8} !== {eg, eo, 1'b1, I8[eo]}) begin
                    errors++;
                    $display("FAIL contention g=%0d c=%0d gnt=%b S=%b busy=%b Y=%b expected %b/%b/1/%b",
                             g, c, gnt8, S8, busy8, Y8, eg, eo, I8[eo]);
                end
            end
        end
        req8 = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_early_release;
        apply_reset();
        req8 = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt8, S8, busy8} !== 7'b0001_00_1) begin
                errors++;
                $display("FAIL early_hold c=%0d gnt=%b S=%b busy=%b expected 0001/00/1", c, gnt8, S8, busy8);
            end
        end
        req8 = 4'b1000;
        @(negedge clk);
        checks++;
        if ({gnt8, S8, busy8} !== 7'b1000_11_1) begin
            errors++;
            $display("FAIL early_handover gnt=%b S=%b busy=%b expected 1000/11/1", gnt8, S8, busy8);
        end
        req8 = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_lone;
        apply_reset();
        req8 = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt8, S8, busy8} !== 7'b0010_01_1) begin
                errors++;
                $display("FAIL lone c=%0d gnt=%b S=%b busy=%b expected 0010/01/1", c, gnt8, S8, busy8);
            end
        end
        req8 = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_max_hold_1;
        logic [1:0] eo;
        logic [3:0] eg;
        apply_reset();
        req1 = 4'b0011;
        I1   = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            eo = 2'(k % 2);
            eg = 4'b0001 << eo;
            checks++;
            if ({gnt1, S1, busy1, Y1} !== {eg, eo, 1'b1, I1[eo]}) begin
                errors++;
                $display("FAIL hold1 k=%0d gnt=%b S=%b busy=%b Y=%b expected %b/%b/1/%b",
                         k, gnt1, S1, busy1, Y1, eg, eo, I1[eo]);
            end
        end
        req1 = 4'b0000;
        @(negedge clk);
        checks++;
        if ({gnt1, S1, busy1, Y1} !== 8'b0000_01_0_0) begin
            errors++;
            $display("FAIL hold1_idle gnt=%b S=%b busy=%b Y=%b expected 0000/01/0/0", gnt1, S1, busy1, Y1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req8  = 4'b0000;
        I8    = 4'b0000;
        req1  = 4'b0000;
        I1    = 4'b0000;
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_lone();
        test_max_hold_1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
